// File: rtl/ram_ctrl.sv
// Byte-serial load/store controller for a byte-wide async-read RAM: one byte per cycle, little-endian.
// Latency N+1 cycles after acceptance (1 for illegal requests); req is only sampled in IDLE.
module ram_ctrl #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              ram_r_wn,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              illegal;
   logic [1:0]        last_cnt;

   function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] sz,
                                          input logic u);
      case (sz)
         2'b00:   extend = {{24{~u & b[7]}}, b[7:0]};
         2'b01:   extend = {{16{~u & b[15]}}, b[15:0]};
         default: extend = b;
      endcase
   endfunction

   assign illegal = (size == 2'b11) ||
                    (size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00);

   always_comb begin
      case (size_q)
         2'b00:   last_cnt = 2'd0;
         2'b01:   last_cnt = 2'd1;
         default: last_cnt = 2'd3;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      buf_d   = buf_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (illegal) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  we_d    = we;
                  size_d  = size;
                  uns_d   = uns;
                  addr_d  = addr;
                  wdata_d = wdata;
                  cnt_d   = 2'd0;
                  err_d   = 1'b0;
                  state_d = XFER;
               end
            end
         end
         XFER: begin
            if (!we_q) buf_d[{cnt_q, 3'b000} +: 8] = ram_rdata;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == last_cnt) begin
               state_d = DONE;
               // Final byte is merged before extension so rdata is valid alongside done.
               if (!we_q) rdata_d = extend(buf_d, size_q, uns_q);
            end
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         buf_q   <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err       = done & err_q;
   assign rdata     = rdata_q;
   // Reset gates the write strobe directly so the reset edge can never commit a store byte.
   assign ram_r_wn  = ~(rst_n & we_q & (state_q == XFER));
   assign ram_addr  = (state_q == XFER) ? addr_q + ADDR_W'(cnt_q) : addr_q;
   assign ram_wdata = (state_q == XFER && we_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: directed vector table, held-req and mid-store reset sequences,
// then random requests against a byte-array reference model.
module tb_ram_ctrl;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n, req, we, uns;
   logic [1:0]    size;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          busy, done, err, ram_r_wn;
   logic [31:0]   rdata;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata, ram_rdata;

   logic [7:0]    mem     [4096];
   logic [7:0]    ref_mem [4096];
   logic [31:0]   model_rdata;
   int            checks = 0;
   int            errors = 0;

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [11:0] a;
      logic [31:0] wd;
      int          lat;
      logic        e;
      logic [31:0] rd;
   } vec_t;
   vec_t vecs[10];

   always #5 clk = ~clk;

   ram_ctrl #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .size      (size),
      .uns       (uns),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .ram_r_wn  (ram_r_wn),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   assign ram_rdata = mem[ram_addr];
   always @(posedge clk) if (!ram_r_wn) mem[ram_addr] = ram_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk($sformatf("%s busy", tag), 32'(busy), 32'd0);
      chk($sformatf("%s done", tag), 32'(done), 32'd0);
      chk($sformatf("%s err", tag), 32'(err), 32'd0);
      chk($sformatf("%s rdata", tag), rdata, 32'd0);
      chk($sformatf("%s ram_r_wn", tag), 32'(ram_r_wn), 32'd1);
      chk($sformatf("%s ram_addr", tag), 32'(ram_addr), 32'd0);
      chk($sformatf("%s ram_wdata", tag), 32'(ram_wdata), 32'd0);
   endtask

   // Reference: legality from size/alignment, N = 1/2/4 bytes, little-endian byte array.
   task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a,
                        input logic [31:0] wd, output int lat, output logic e,
                        output logic [31:0] rd);
      int n;
      logic [31:0] v;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (sz == 2'd3 || (int'(a) % n) != 0) begin
         lat = 1;
         e   = 1'b1;
      end else begin
         lat = n + 1;
         e   = 1'b0;
         if (w) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
         end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
            if (n < 4 && !u && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            model_rdata = v;
         end
      end
      rd = model_rdata;
   endtask

   // Entered and left just after a rising edge with the DUT idle.
   task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [11:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rd);
      int got, wr, nbytes;
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      got = 0;
      wr  = 0;
      we = w; size = sz; uns = u; addr = a; wdata = wd; req = 1'b1;
      @(negedge clk);
      chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
      if (!ram_r_wn) wr++;
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 1; c <= 8 && got == 0; c++) begin
         @(negedge clk);
         if (!ram_r_wn) begin
            chk($sformatf("%s waddr", tag), 32'(ram_addr), 32'(a) + 32'(wr));
            chk($sformatf("%s wbyte", tag), 32'(ram_wdata), (wd >> (8 * wr)) & 32'hFF);
            wr++;
         end
         if (done) begin
            got = c;
            chk($sformatf("%s err", tag), 32'(err), 32'(exp_err));
            chk($sformatf("%s rdata", tag), rdata, exp_rd);
         end
      end
      chk($sformatf("%s latency", tag), 32'(got), 32'(exp_lat));
      chk($sformatf("%s writes", tag), 32'(wr), (w && !exp_err) ? 32'(nbytes) : 32'd0);
      @(posedge clk); #1;
      chk($sformatf("%s after done", tag), {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          dl, elat, nmis;
      logic        de, eerr, rw, ru;
      logic [31:0] dr, erd, rwd;
      logic [1:0]  rsz;
      logic [11:0] ra;

      vecs[0] = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 5, 1'b0, 32'h0000_0000};
      vecs[1] = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        5, 1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 2'd0, 1'b0, 12'h013, 32'h0,        2, 1'b0, 32'hFFFFFFDE};
      vecs[3] = '{1'b0, 2'd0, 1'b1, 12'h010, 32'h0,        2, 1'b0, 32'h000000EF};
      vecs[4] = '{1'b0, 2'd1, 1'b1, 12'h012, 32'h0,        3, 1'b0, 32'h0000DEAD};
      vecs[5] = '{1'b0, 2'd1, 1'b0, 12'h010, 32'h0,        3, 1'b0, 32'hFFFFBEEF};
      vecs[6] = '{1'b1, 2'd1, 1'b0, 12'h011, 32'h0000CAFE, 1, 1'b1, 32'hFFFFBEEF};
      vecs[7] = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        5, 1'b0, 32'hDEADBEEF};
      vecs[8] = '{1'b0, 2'd3, 1'b0, 12'h014, 32'h0,        1, 1'b1, 32'hDEADBEEF};
      vecs[9] = '{1'b0, 2'd2, 1'b0, 12'h012, 32'h0,        1, 1'b1, 32'hDEADBEEF};

      rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = 32'd0;
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      model_rdata = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, dl, de, dr);
         run_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a,
                 vecs[i].wd, vecs[i].lat, vecs[i].e, vecs[i].rd);
      end

      // req held high with byte loads: accept, XFER, DONE repeating every 3 cycles.
      we = 1'b0; size = 2'd0; uns = 1'b1; addr = 12'h010; wdata = 32'd0; req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk($sformatf("hold c%0d busy", c), 32'(busy), 32'((c % 3) != 1));
         chk($sformatf("hold c%0d done", c), 32'(done), 32'((c % 3) == 0));
         if ((c % 3) == 0) chk($sformatf("hold c%0d rdata", c), rdata, 32'h0000_00EF);
         @(posedge clk); #1;
      end
      req = 1'b0;
      model_rdata = 32'h0000_00EF;

      // Reset asserted in the third XFER cycle of a word store.
      we = 1'b1; size = 2'd2; uns = 1'b0; addr = 12'h020; wdata = 32'h1122_3344; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         chk($sformatf("rststore x%0d done", c), 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("rststore forced r_wn", 32'(ram_r_wn), 32'd1);
      chk("rststore x3 done", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk_reset("rststore");
      rst_n = 1'b1;
      chk("rststore mem20", 32'(mem[12'h020]), 32'h44);
      chk("rststore mem21", 32'(mem[12'h021]), 32'h33);
      chk("rststore mem22", 32'(mem[12'h022]), 32'(ref_mem[12'h022]));
      chk("rststore mem23", 32'(mem[12'h023]), 32'(ref_mem[12'h023]));
      ref_mem[12'h020] = 8'h44;
      ref_mem[12'h021] = 8'h33;
      model_rdata = 32'd0;
      @(posedge clk); #1;
      chk("post reset idle", {30'd0, done, busy}, 32'd0);

      for (int k = 0; k < 60; k++) begin
         rsz = 2'($urandom_range(0, 3));
         ra  = 12'($urandom);
         if ($urandom_range(0, 3) != 0)
            ra = ra & ((rsz == 2'd1) ? 12'hFFE : (rsz == 2'd2) ? 12'hFFC : 12'hFFF);
         if ($urandom_range(0, 3) == 0) ra = 12'h010 + (ra & 12'h00F);
         rw  = 1'($urandom);
         ru  = 1'($urandom);
         rwd = $urandom;
         model(rw, rsz, ru, ra, rwd, elat, eerr, erd);
         run_req($sformatf("rnd%0d", k), rw, rsz, ru, ra, rwd, elat, eerr, erd);
      end

      nmis = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nmis++;
      chk("mem image", 32'(nmis), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the byte-address width of the attached byte-wide data RAM (4096 bytes).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port req  input  1  a load/store request, sampled only in IDLE.
REQ-005 The block SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 The block SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 The block SHALL have port uns  input  1  a load zero-extends when 1 and sign-extends when 0.
REQ-008 The block SHALL have port addr  input  ADDR_W  the byte address of the request.
REQ-009 The block SHALL have port wdata  input  32  store data, with the least-significant bytes used for byte and halfword stores.
REQ-010 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 The block SHALL have port done  output  1  a one-cycle completion pulse.
REQ-012 The block SHALL have port err  output  1  misaligned or illegal request, valid only with done.
REQ-013 The block SHALL have port rdata  output  32  extended load result.
REQ-014 The block SHALL have port ram_r_wn  output  1  RAM read/write select, where 0 writes on the next rising edge.
REQ-015 The block SHALL have port ram_addr  output  ADDR_W  RAM byte address.
REQ-016 The block SHALL have port ram_wdata  output  8  RAM write byte.
REQ-017 The block SHALL have port ram_rdata  input  8  RAM read byte, which is combinational from ram_addr (asynchronous read).

Function
REQ-018 The block SHALL implement an FSM with the states IDLE, XFER and DONE.
REQ-019 In IDLE with req=1, a legal request SHALL latch we, size, uns, addr and wdata, clear the byte counter cnt, and go to XFER.
REQ-020 In IDLE with req=1, an illegal request SHALL go directly to DONE with err pending; an illegal request is size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-021 An illegal request SHALL NOT assert ram_r_wn=0 in any cycle and SHALL leave rdata unchanged.
REQ-022 The number of transfer bytes N SHALL be 1, 2 or 4 for byte, halfword and word, in little-endian order.
REQ-023 In XFER, the block SHALL drive ram_addr = latched addr + cnt.
REQ-024 In XFER for a store, the block SHALL drive ram_r_wn=0 and ram_wdata = wdata[8*cnt+7:8*cnt].
REQ-025 In XFER for a load, the block SHALL drive ram_r_wn=1 and capture ram_rdata into byte cnt of an internal buffer at the clock edge.
REQ-026 In XFER, cnt SHALL increment by 1 per cycle, and when cnt=N-1 the next state SHALL be DONE.
REQ-027 DONE SHALL last exactly one cycle with done=1, followed by a return to IDLE; err SHALL be 1 in that cycle only for illegal requests.
REQ-028 On a load completion, rdata SHALL update to the buffer sign-extended or zero-extended from bit 7 or 15 according to uns.
REQ-029 rdata SHALL be valid when done=1 and SHALL hold until the next load completion; stores and errors SHALL NOT change rdata.
REQ-030 Latency, with req sampled at the end of cycle T, SHALL be: byte done in cycle T+2, halfword in T+3, word in T+5, illegal request in T+1.
REQ-031 req SHALL be ignored while busy=1; a req held high in the DONE cycle SHALL NOT be accepted until IDLE.
REQ-032 Back-to-back throughput SHALL be one accepted request per N+2 cycles.
REQ-033 Outside XFER, ram_r_wn SHALL be 1, ram_addr SHALL equal the latched addr, and ram_wdata SHALL be 0.
REQ-034 Address wrap SHALL be impossible for legal requests, since alignment keeps addr+N-1 at or below 4095; no wrap logic is required.

Reset
REQ-035 While rst_n=0, ram_r_wn SHALL be forced to 1 combinationally, so that no RAM write occurs on the reset edge even mid-XFER.
REQ-036 At the first rising edge with rst_n=0, the block SHALL apply: state=IDLE, cnt=0, busy=0, done=0, err=0, rdata=0, latched addr=0, ram_addr=0, ram_wdata=0, and the buffer cleared.
REQ-037 A transfer interrupted by reset SHALL be abandoned; bytes already written remain in RAM, and no done is produced.

Verification
REQ-038 The bench SHALL cover a word store: SW wdata=0xDEADBEEF at addr 0x010 -> RAM 0x010..0x013 = EF, BE, AD, DE over four consecutive cycles with ram_r_wn=0, done in T+5, err=0.
REQ-039 The bench SHALL cover a word load: LW at addr 0x010 after REQ-038 -> rdata=0xDEADBEEF with done in T+5, and ram_r_wn=1 throughout.
REQ-040 The bench SHALL cover narrow loads and their extension: LB uns=0 at 0x013 -> 0xFFFFFFDE; LBU at 0x010 -> 0x000000EF; LHU at 0x012 -> 0x0000DEAD; LH at 0x010 -> 0xFFFFBEEF.
REQ-041 The bench SHALL cover a misaligned store: SH at 0x011 -> done and err in T+1, ram_r_wn never 0, RAM and rdata unchanged.
REQ-042 The bench SHALL cover reset mid-store: SW 0x11223344 at 0x020 with rst_n=0 in the third XFER cycle -> RAM 0x020=44 and 0x021=33, 0x022 and 0x023 untouched, no done, and all outputs at reset values.
REQ-043 The bench SHALL cover req held high continuously with byte loads -> accepts spaced 3 cycles apart, done pulses exactly one cycle each, and no request accepted while busy=1.
